// File: rtl/config_reg_ctrl.sv
// Boot loader and round-robin arbiter in front of the 8 x 16-bit config_reg port.
// States: INIT boot writes | IDLE arbitrate | WR write + ack | RD_ADDR present address | RD_CAP read ack
module config_reg_ctrl #(
    parameter int           NUM_INIT  = 8,
    parameter logic [127:0] INIT_VALS = 128'h0007_0006_0005_0004_0003_0002_0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        init_done,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [2:0]  m0_addr,
    input  logic [15:0] m0_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [2:0]  m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic        cfg_write,
    output logic [2:0]  cfg_address,
    output logic [15:0] cfg_data_in,
    input  logic [15:0] cfg_data_out
);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_WR      = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_CAP  = 3'd4
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(NUM_INIT - 1);

    state_t      state_q, state_d;
    logic [2:0]  init_idx_q, init_idx_d;
    logic        last_served_q, last_served_d;
    logic        master_q, master_d;
    logic        init_done_q, init_done_d;
    logic        cfg_write_q, cfg_write_d;
    logic [2:0]  cfg_address_q, cfg_address_d;
    logic [15:0] cfg_data_in_q, cfg_data_in_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m1_ack_q, m1_ack_d;
    logic [15:0] m0_rdata_q, m0_rdata_d;
    logic [15:0] m1_rdata_q, m1_rdata_d;

    logic        grant_m0;
    logic        grant_m1;
    logic        sel_we;

    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        last_served_d = last_served_q;
        master_d      = master_q;
        init_done_d   = init_done_q;
        cfg_write_d   = 1'b0;
        cfg_address_d = cfg_address_q;
        cfg_data_in_d = cfg_data_in_q;
        m0_ack_d      = 1'b0;
        m1_ack_d      = 1'b0;
        m0_rdata_d    = m0_rdata_q;
        m1_rdata_d    = m1_rdata_q;
        grant_m0      = 1'b0;
        grant_m1      = 1'b0;
        sel_we        = 1'b0;

        case (state_q)
            S_INIT: begin
                cfg_write_d   = 1'b1;
                cfg_address_d = init_idx_q;
                cfg_data_in_d = INIT_VALS[{init_idx_q, 4'b0000} +: 16];
                if (init_idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    init_idx_d = init_idx_q + 3'd1;
                end
            end
            S_IDLE: begin
                init_done_d = 1'b1;
                // On a tie the master that was not served last wins.
                grant_m0 = m0_req && (!m1_req || last_served_q);
                grant_m1 = m1_req && !grant_m0;
                if (grant_m0 || grant_m1) begin
                    master_d      = grant_m1;
                    last_served_d = grant_m1;
                    sel_we        = grant_m1 ? m1_we : m0_we;
                    cfg_address_d = grant_m1 ? m1_addr : m0_addr;
                    if (sel_we) begin
                        cfg_write_d   = 1'b1;
                        cfg_data_in_d = grant_m1 ? m1_wdata : m0_wdata;
                        m0_ack_d      = grant_m0;
                        m1_ack_d      = grant_m1;
                        state_d       = S_WR;
                    end else begin
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                state_d = S_IDLE;
            end
            S_RD_ADDR: begin
                if (master_q) begin
                    m1_rdata_d = cfg_data_out;
                    m1_ack_d   = 1'b1;
                end else begin
                    m0_rdata_d = cfg_data_out;
                    m0_ack_d   = 1'b1;
                end
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_INIT;
            init_idx_q    <= 3'd0;
            last_served_q <= 1'b1;
            master_q      <= 1'b0;
            init_done_q   <= 1'b0;
            cfg_write_q   <= 1'b0;
            cfg_address_q <= 3'd0;
            cfg_data_in_q <= 16'h0000;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
            m0_rdata_q    <= 16'h0000;
            m1_rdata_q    <= 16'h0000;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            last_served_q <= last_served_d;
            master_q      <= master_d;
            init_done_q   <= init_done_d;
            cfg_write_q   <= cfg_write_d;
            cfg_address_q <= cfg_address_d;
            cfg_data_in_q <= cfg_data_in_d;
            m0_ack_q      <= m0_ack_d;
            m1_ack_q      <= m1_ack_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
        end
    end

    assign init_done   = init_done_q;
    assign cfg_write   = cfg_write_q;
    assign cfg_address = cfg_address_q;
    assign cfg_data_in = cfg_data_in_q;
    assign m0_ack      = m0_ack_q;
    assign m1_ack      = m1_ack_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;

endmodule

// File: tb/tb_config_reg_ctrl.sv
// Directed bench for config_reg_ctrl with a behavioural config_reg model.
module tb_config_reg_ctrl;

    logic        clk;
    logic        reset;
    logic        init_done;
    logic        m0_req, m0_we, m0_ack;
    logic [2:0]  m0_addr;
    logic [15:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [2:0]  m1_addr;
    logic [15:0] m1_wdata, m1_rdata;
    logic        cfg_write;
    logic [2:0]  cfg_address;
    logic [15:0] cfg_data_in, cfg_data_out;

    int n_cmp = 0;
    int n_mis = 0;
    logic prev_m0 = 1'b0;
    logic prev_m1 = 1'b0;

    typedef struct {
        logic        mst;
        logic        we;
        logic [2:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    config_reg_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .init_done    (init_done),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_ack       (m0_ack),
        .m0_rdata     (m0_rdata),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_ack       (m1_ack),
        .m1_rdata     (m1_rdata),
        .cfg_write    (cfg_write),
        .cfg_address  (cfg_address),
        .cfg_data_in  (cfg_data_in),
        .cfg_data_out (cfg_data_out)
    );

    // config_reg model: flopped storage, read port follows the address
    logic [15:0] mem [8] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (cfg_write) mem[cfg_address] <= cfg_data_in;
    end
    assign cfg_data_out = mem[cfg_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("ack_exclusive", 32'(m0_ack & m1_ack), 32'd0);
        check("m0_ack_pulse", 32'(prev_m0 & m0_ack), 32'd0);
        check("m1_ack_pulse", 32'(prev_m1 & m1_ack), 32'd0);
        prev_m0 = m0_ack;
        prev_m1 = m1_ack;
    endtask

    task automatic boot_check(input string tag);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("%s_wr%0d", tag, i), 32'(cfg_write), 32'd1);
            check($sformatf("%s_addr%0d", tag, i), 32'(cfg_address), 32'(i));
            check($sformatf("%s_data%0d", tag, i), 32'(cfg_data_in), 32'(i));
            check($sformatf("%s_done%0d", tag, i), 32'(init_done), 32'd0);
            check($sformatf("%s_noack%0d", tag, i), 32'(m0_ack | m1_ack), 32'd0);
        end
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        logic got;
        int   lat;
        logic ack_x;
        got = 1'b0;
        lat = 0;
        if (v.mst) begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end else begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end
        for (int c = 1; c <= 20; c++) begin
            step();
            if (!v.we) check({tag, "_rd_cfg_write"}, 32'(cfg_write), 32'd0);
            // After the grant edge: drop req and scramble payload; the read must still finish
            if (!v.we && c == 1) begin
                if (v.mst) begin
                    m1_req = 1'b0; m1_addr = ~v.addr; m1_wdata = 16'hDEAD;
                end else begin
                    m0_req = 1'b0; m0_addr = ~v.addr; m0_wdata = 16'hDEAD;
                end
            end
            ack_x = v.mst ? m1_ack : m0_ack;
            if (ack_x) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        check({tag, "_ack_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(lat), v.we ? 32'd1 : 32'd2);
        if (v.we) begin
            check({tag, "_cfg_write"}, 32'(cfg_write), 32'd1);
            check({tag, "_cfg_addr"}, 32'(cfg_address), 32'(v.addr));
            check({tag, "_cfg_data"}, 32'(cfg_data_in), 32'(v.wdata));
        end else begin
            check({tag, "_rdata"}, 32'(v.mst ? m1_rdata : m0_rdata), 32'(v.exp_rdata));
            check({tag, "_cfg_addr"}, 32'(cfg_address), 32'(v.addr));
        end
        if (v.mst) m1_req = 1'b0; else m0_req = 1'b0;
        step();
        check({tag, "_ack_drop"}, 32'(m0_ack | m1_ack), 32'd0);
        check({tag, "_wr_drop"}, 32'(cfg_write), 32'd0);
    endtask

    initial begin
        int   k;
        int   last_c;
        logic [15:0] d0, d1;
        vec_t pv;

        vecs[0] = '{1'b0, 1'b1, 3'd4, 16'h2025, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 3'd4, 16'h0000, 16'h2025};
        vecs[2] = '{1'b0, 1'b0, 3'd2, 16'h0000, 16'h0002};
        vecs[3] = '{1'b1, 1'b1, 3'd7, 16'hBEEF, 16'h0000};
        vecs[4] = '{1'b0, 1'b0, 3'd7, 16'h0000, 16'hBEEF};
        vecs[5] = '{1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000};
        vecs[6] = '{1'b0, 1'b1, 3'd0, 16'hA5A5, 16'h0000};
        vecs[7] = '{1'b1, 1'b0, 3'd0, 16'h0000, 16'hA5A5};
        vecs[8] = '{1'b1, 1'b0, 3'd3, 16'h0000, 16'h0003};

        reset = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 3'd0; m0_wdata = 16'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 3'd0; m1_wdata = 16'h0;

        // Reset state and boot load
        for (int i = 0; i < 3; i++) step();
        check("rst_outputs", 32'({init_done, cfg_write, cfg_address, cfg_data_in, m0_ack, m1_ack}), 32'd0);
        check("rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
        reset = 1'b0;
        boot_check("boot");
        step();
        check("boot_done", 32'(init_done), 32'd1);
        check("boot_idle_wr", 32'(cfg_write), 32'd0);

        // Single-master transactions
        for (int i = 0; i < 9; i++) do_txn(vecs[i], $sformatf("v%0d", i));
        check("m0_rdata_hold", 32'(m0_rdata), 32'hBEEF);
        check("m1_rdata_hold", 32'(m1_rdata), 32'h0003);

        // Round-robin with both masters writing continuously
        d0 = 16'h1000; d1 = 16'h2000;
        m0_we = 1'b1; m0_addr = 3'd5; m0_wdata = d0; m0_req = 1'b1;
        m1_we = 1'b1; m1_addr = 3'd6; m1_wdata = d1; m1_req = 1'b1;
        k = 0; last_c = 0;
        for (int c = 1; c <= 40 && k < 4; c++) begin
            step();
            if (m0_ack | m1_ack) begin
                check($sformatf("rr_order%0d", k), 32'(m1_ack), 32'(k & 1));
                check($sformatf("rr_addr%0d", k), 32'(cfg_address), (k & 1) ? 32'd6 : 32'd5);
                check($sformatf("rr_data%0d", k), 32'(cfg_data_in), 32'((k & 1) ? d1 : d0));
                if (k > 0) check($sformatf("rr_gap%0d", k), 32'(c - last_c), 32'd2);
                if (m1_ack) begin
                    d1 = d1 + 16'd1; m1_wdata = d1;
                end else begin
                    d0 = d0 + 16'd1; m0_wdata = d0;
                end
                last_c = c;
                k++;
                if (k == 4) begin
                    m0_req = 1'b0; m1_req = 1'b0;
                end
            end
        end
        check("rr_count", 32'(k), 32'd4);
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        check("rr_quiet", 32'(m0_ack | m1_ack | cfg_write), 32'd0);

        // Reset during RD_ADDR of an m0 read
        m0_we = 1'b0; m0_addr = 3'd5; m0_req = 1'b1;
        step();
        reset = 1'b1;
        m0_req = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({init_done, cfg_write, cfg_address, cfg_data_in, m0_ack, m1_ack}), 32'd0);
        check("mid_rst_rdata", 32'({m0_rdata, m1_rdata}), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("mid_rst_no_ack", 32'(m0_ack | m1_ack), 32'd0);
        end

        // m1 request pending from release is served in the first IDLE after boot
        reset = 1'b0;
        m1_we = 1'b1; m1_addr = 3'd1; m1_wdata = 16'h5A5A; m1_req = 1'b1;
        boot_check("reboot");
        step();
        check("pend_done", 32'(init_done), 32'd1);
        check("pend_ack", 32'(m1_ack), 32'd1);
        check("pend_wr", 32'(cfg_write), 32'd1);
        check("pend_addr", 32'(cfg_address), 32'd1);
        check("pend_data", 32'(cfg_data_in), 32'h5A5A);
        m1_req = 1'b0;
        step();
        check("pend_ack_drop", 32'(m1_ack), 32'd0);

        pv = '{1'b0, 1'b0, 3'd4, 16'h0000, 16'h0004};
        do_txn(pv, "post0");
        pv = '{1'b1, 1'b0, 3'd1, 16'h0000, 16'h5A5A};
        do_txn(pv, "post1");
        check("done_sticky", 32'(init_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
